ref10_out_gen: RTL and testbench

- Derives a 10 MHz reference output from the 200 MHz MMCM clock by dividing by 20.
- The 10 MHz edge is phase-aligned to the board PPS input.
- Measures the PPS-to-10 MHz phase offset each second and flags loss of PPS.
- Sits downstream of the 10-to-200 MHz MMCM; feeds the 10 MHz SMA/output buffer and the status registers.

---
 rtl/ref10_out_gen_if.sv | 44 ++++
 rtl/ref10_out_gen.sv | 154 +++++++++++++++
 tb/tb_ref10_out_gen.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ref10_out_gen_if.sv
// Purpose: groups the reference-generator control inputs and status/clock outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle pulses.
//
// Ports (slave = ref10_out_gen side):
//   mmcm_locked, enable, realign_en, pps_in -> into the generator
//   clk_out, aligned, phase_offset[CW], phase_valid, pps_lost -> out of the generator
interface ref10_out_gen_if #(
    parameter int CW = 5
);
    logic          mmcm_locked;
    logic          enable;
    logic          realign_en;
    logic          pps_in;
    logic          clk_out;
    logic          aligned;
    logic [CW-1:0] phase_offset;
    logic          phase_valid;
    logic          pps_lost;

    modport slave (
        input  mmcm_locked,
        input  enable,
        input  realign_en,
        input  pps_in,
        output clk_out,
        output aligned,
        output phase_offset,
        output phase_valid,
        output pps_lost
    );

    modport master (
        output mmcm_locked,
        output enable,
        output realign_en,
        output pps_in,
        input  clk_out,
        input  aligned,
        input  phase_offset,
        input  phase_valid,
        input  pps_lost
    );
endinterface

// File: rtl/ref10_out_gen.sv
// Purpose: divides clk_in1 by DIVIDE into a PPS-aligned reference, measures PPS phase, flags PPS loss.
// Latency: clk_out rises 3 clk_in1 edges after pps_in is driven high (2-flop sync + edge-detect + output reg).
// Backpressure: none; outputs are free-running, phase_valid is a single-cycle pulse.
//
// Ports: clk_in1 (MMCM clock), rst (sync, active-high),
//        io.slave: mmcm_locked/pps_in (async, synchronised here), enable, realign_en,
//                  clk_out, aligned, phase_offset, phase_valid, pps_lost.
module ref10_out_gen #(
    parameter int DIVIDE      = 20,
    parameter int HIGH_CYCLES = 10,
    parameter int PPS_TIMEOUT = 210000000,
    parameter int CW          = $clog2(DIVIDE)
) (
    input  logic            clk_in1,
    input  logic            rst,
    ref10_out_gen_if.slave  io
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDE - 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'(HIGH_CYCLES);
    localparam logic [27:0]   TO_LIM   = 28'(PPS_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PPS = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [1:0]    lock_sync_q;
    logic [2:0]    pps_sync_q;
    logic          locked_sync;
    logic          pps_pulse;
    logic          run_ok;
    logic [27:0]   tcnt;
    logic [27:0]   tcnt_next;

    logic          clk_out_q;
    logic          aligned_q;
    logic [CW-1:0] phase_offset_q;
    logic          phase_valid_q;
    logic          pps_lost_q;

    // Bits [1:0] of pps_sync_q form the synchroniser; bit 2 is the edge-detect
    // history, so a long-held pps_in yields exactly one pulse.
    always_ff @(posedge clk_in1) begin
        if (rst) begin
            lock_sync_q <= '0;
            pps_sync_q  <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], io.mmcm_locked};
            pps_sync_q  <= {pps_sync_q[1:0], io.pps_in};
        end
    end

    assign locked_sync = lock_sync_q[1];
    assign pps_pulse   = pps_sync_q[1] & ~pps_sync_q[2];
    assign run_ok      = locked_sync & io.enable;
    assign cnt_next    = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

    // Loss-of-PPS watchdog runs in every state so holdover in RUN is visible.
    assign tcnt_next = pps_pulse          ? '0   :
                       (tcnt == TO_LIM)   ? tcnt : tcnt + 28'd1;

    always_ff @(posedge clk_in1) begin
        if (rst) begin
            tcnt       <= '0;
            pps_lost_q <= 1'b0;
        end else begin
            tcnt <= tcnt_next;
            if (pps_pulse) begin
                pps_lost_q <= 1'b0;
            end else if (tcnt_next == TO_LIM) begin
                pps_lost_q <= 1'b1;
            end
        end
    end

    // cnt and clk_out are both loaded from the same next-count, so clk_out is
    // high exactly while cnt < HIGH_CYCLES. The PPS cycle itself is count 0,
    // hence the reload value of 1 on alignment.
    always_ff @(posedge clk_in1) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            clk_out_q      <= 1'b0;
            aligned_q      <= 1'b0;
            phase_offset_q <= '0;
            phase_valid_q  <= 1'b0;
        end else begin
            phase_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    clk_out_q <= 1'b0;
                    aligned_q <= 1'b0;
                    cnt       <= '0;
                    if (run_ok) begin
                        state <= WAIT_PPS;
                    end
                end
                WAIT_PPS: begin
                    clk_out_q <= 1'b0;
                    aligned_q <= 1'b0;
                    if (!run_ok) begin
                        state <= IDLE;
                    end else if (pps_pulse) begin
                        cnt       <= CW'(1);
                        clk_out_q <= 1'b1;
                        aligned_q <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // Lock/enable loss takes priority over a coincident PPS.
                    if (!run_ok) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        clk_out_q <= 1'b0;
                        aligned_q <= 1'b0;
                    end else begin
                        aligned_q <= 1'b1;
                        if (pps_pulse) begin
                            phase_offset_q <= cnt;
                            phase_valid_q  <= 1'b1;
                        end
                        // On-grid PPS (cnt==0) needs no reload; the edge is already there.
                        if (pps_pulse && (cnt != '0) && io.realign_en) begin
                            cnt       <= CW'(1);
                            clk_out_q <= 1'b1;
                        end else begin
                            cnt       <= cnt_next;
                            clk_out_q <= (cnt_next < CNT_HIGH);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    clk_out_q <= 1'b0;
                    aligned_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.clk_out      = clk_out_q;
    assign io.aligned      = aligned_q;
    assign io.phase_offset = phase_offset_q;
    assign io.phase_valid  = phase_valid_q;
    assign io.pps_lost     = pps_lost_q;

endmodule

// File: tb/tb_ref10_out_gen.sv
// Purpose: self-checking bench for ref10_out_gen (PPS_TIMEOUT shortened to 500).
// Latency: expected clk_out derived from a grid reference (cycle of the last aligned rising edge).
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_ref10_out_gen;
    localparam int DIVIDE = 20;
    localparam int HIGH   = 10;
    localparam int TO     = 500;
    localparam int CW     = 5;

    logic clk_in1 = 1'b0;
    logic rst     = 1'b1;

    ref10_out_gen_if #(.CW(CW)) io();

    ref10_out_gen #(
        .DIVIDE(DIVIDE), .HIGH_CYCLES(HIGH), .PPS_TIMEOUT(TO), .CW(CW)
    ) dut (
        .clk_in1 (clk_in1),
        .rst     (rst),
        .io      (io.slave)
    );

    always #2.5 clk_in1 = ~clk_in1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk_in1) cyc <= cyc + 1;

    typedef struct {
        bit realign;     // realign_en during this PPS
        int off;         // grid position at which the PPS pulse lands
        int exp_offset;  // expected phase_offset
        bit exp_clk_d3;  // expected clk_out 3 edges after pps_in driven
    } vec_t;
    vec_t vecs[7];

    int queue_dummy;
    int exp_q[$];
    logic pv_prev = 1'b0;

    int  grid_ref  = 0;
    int  pend_grid = -1;
    int  pps_drop  = -1;
    bit  model_on  = 1'b0;
    int  clk_bad   = 0;
    int  al_bad    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_clk();
        return (((cyc - grid_ref + 1) % DIVIDE) < HIGH);
    endfunction

    task automatic tick();
        @(posedge clk_in1);
        #1;
        if (pend_grid == cyc) begin
            grid_ref  = pend_grid;
            pend_grid = -1;
        end
        if (pps_drop == cyc) io.pps_in = 1'b0;
        if (model_on) begin
            if (io.clk_out !== exp_clk()) clk_bad++;
            if (io.aligned !== 1'b1) al_bad++;
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic start_model();
        model_on = 1'b1;
        clk_bad  = 0;
        al_bad   = 0;
    endtask

    task automatic end_model(input string name);
        model_on = 1'b0;
        check({name, "_clk_shape"}, clk_bad, 0);
        check({name, "_aligned"}, al_bad, 0);
    endtask

    task automatic drive_pps(input int d, input bit push, input int off);
        wait_cyc(d);
        io.pps_in = 1'b1;
        pps_drop  = d + 30;
        if (push) exp_q.push_back(off);
    endtask

    // Scoreboard: every phase_valid must match a queued expectation and last one cycle.
    always @(negedge clk_in1) begin
        if (io.phase_valid === 1'b1) begin
            check("pv_width", pv_prev, 0);
            check("pv_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                queue_dummy = exp_q.pop_front();
                check("phase_offset", io.phase_offset, queue_dummy);
            end
        end
        pv_prev = io.phase_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, d, l, idle_bad;
        vecs[0] = '{1'b1, 18, 18, 1'b1};
        vecs[1] = '{1'b1,  0,  0, 1'b1};
        vecs[2] = '{1'b1,  5,  5, 1'b1};
        vecs[3] = '{1'b0, 18, 18, 1'b0};
        vecs[4] = '{1'b0,  0,  0, 1'b1};
        vecs[5] = '{1'b0, 12, 12, 1'b0};
        vecs[6] = '{1'b1,  0,  0, 1'b1};

        io.mmcm_locked = 1'b0;
        io.enable      = 1'b0;
        io.realign_en  = 1'b0;
        io.pps_in      = 1'b0;
        repeat (4) tick();
        check("rst_clk_out", io.clk_out, 0);
        check("rst_aligned", io.aligned, 0);
        check("rst_phase_offset", io.phase_offset, 0);
        check("rst_phase_valid", io.phase_valid, 0);
        check("rst_pps_lost", io.pps_lost, 0);

        // Locked and enabled, no PPS: outputs stay low, timeout fires at 500.
        rst = 1'b0;
        io.mmcm_locked = 1'b1;
        io.enable      = 1'b1;
        io.realign_en  = 1'b1;
        r = cyc;
        idle_bad = 0;
        while (cyc < r + 1000) begin
            tick();
            if (io.clk_out !== 1'b0) idle_bad++;
            if (io.aligned !== 1'b0) idle_bad++;
            if (cyc == r + 499) check("lost_not_yet_boot", io.pps_lost, 0);
            if (cyc == r + 500) check("lost_set_boot", io.pps_lost, 1);
        end
        check("wait_pps_outputs_low", idle_bad, 0);

        // First alignment: rise 3 edges after pps_in is driven.
        d = cyc + 7;
        drive_pps(d, 1'b0, 0);
        wait_cyc(d + 2);
        check("first_rise_pre", io.clk_out, 0);
        wait_cyc(d + 3);
        check("first_rise", io.clk_out, 1);
        check("first_aligned", io.aligned, 1);
        check("first_lost_clear", io.pps_lost, 0);
        grid_ref = d + 3;
        start_model();
        wait_cyc(d + 2003);
        end_model("run2000");

        // Phase-drift table.
        for (int i = 0; i < 7; i++) begin
            io.realign_en = vecs[i].realign;
            d = cyc + 60;
            while (((d + 3 - grid_ref) % DIVIDE) != vecs[i].off) d++;
            start_model();
            drive_pps(d, 1'b1, vecs[i].exp_offset);
            if (vecs[i].realign && vecs[i].off != 0) pend_grid = d + 3;
            wait_cyc(d + 3);
            check($sformatf("v%0d_clk_at_pps3", i), io.clk_out, vecs[i].exp_clk_d3);
            wait_cyc(d + 60);
            end_model($sformatf("v%0d", i));
        end

        // Holdover: PPS withheld, pps_lost at 500 cycles after the last pulse, clock keeps running.
        start_model();
        wait_cyc(d + 502);
        check("lost_499", io.pps_lost, 0);
        wait_cyc(d + 503);
        check("lost_500", io.pps_lost, 1);
        wait_cyc(d + 700);
        end_model("holdover");

        io.realign_en = 1'b1;
        d = cyc + 60;
        while (((d + 3 - grid_ref) % DIVIDE) != 12) d++;
        start_model();
        drive_pps(d, 1'b1, 12);
        pend_grid = d + 3;
        wait_cyc(d + 2);
        check("lost_still_set", io.pps_lost, 1);
        wait_cyc(d + 3);
        check("lost_cleared", io.pps_lost, 0);
        wait_cyc(d + 60);
        end_model("after_holdover");

        // Lock loss mid-high, coincident with a PPS pulse: lock loss wins.
        while (((cyc - grid_ref + 1) % DIVIDE) != 3) tick();
        l = cyc;
        io.mmcm_locked = 1'b0;
        io.pps_in      = 1'b1;
        pps_drop       = l + 20;
        wait_cyc(l + 2);
        check("lockloss_still_high", io.clk_out, 1);
        wait_cyc(l + 3);
        check("lockloss_clk_low", io.clk_out, 0);
        check("lockloss_aligned", io.aligned, 0);
        idle_bad = 0;
        while (cyc < l + 30) begin
            tick();
            if (io.clk_out !== 1'b0) idle_bad++;
        end
        check("lockloss_stays_low", idle_bad, 0);

        // Relock and realign.
        io.mmcm_locked = 1'b1;
        d = l + 60;
        drive_pps(d, 1'b0, 0);
        wait_cyc(d + 2);
        check("relock_rise_pre", io.clk_out, 0);
        wait_cyc(d + 3);
        check("relock_rise", io.clk_out, 1);
        check("relock_aligned", io.aligned, 1);
        grid_ref = d + 3;
        start_model();
        wait_cyc(d + 600);
        end_model("relock");
        check("lost_before_rst", io.pps_lost, 1);
        check("offset_kept", io.phase_offset, 12);

        // Reset mid-RUN.
        rst = 1'b1;
        tick();
        check("rst2_clk_out", io.clk_out, 0);
        check("rst2_aligned", io.aligned, 0);
        check("rst2_phase_offset", io.phase_offset, 0);
        check("rst2_phase_valid", io.phase_valid, 0);
        check("rst2_pps_lost", io.pps_lost, 0);
        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
